ess_decel_detector: RTL and testbench
=====================================

ESS_DECEL_DETECTOR -- requirements
Module: ess_decel_detector

Interface
REQ-001 Parameter MIN_SPEED, default 30, minimum speed (km/h) for arming.
REQ-002 Parameter DECEL_THRESH, default 8, per-sample speed drop (km/h) counted as a hard-braking hit.
REQ-003 Parameter CONFIRM_N, default 2, consecutive hits required to fire; legal range 1..7.
REQ-004 Parameter HOLDOFF_N, default 10, sample ticks of re-arm lockout after ESS ends; legal range 1..255.
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tick_sample  input  1  one-clk pulse per speed sample period (100 ms).
REQ-008 speed  input  8  current vehicle speed, km/h, unsigned.
REQ-009 brake_pressed  input  1  brake pedal level.
REQ-010 is_accel_pressed  input  1  accelerator pedal level.
REQ-011 ess_active  input  1  feedback level from the warning-light block: ESS blinking in progress.
REQ-012 ess_trigger  output  1  registered one-clk pulse requesting ESS start.
REQ-013 decel_out  output  8  registered last computed per-sample deceleration, km/h.
REQ-014 state_out  output  3  registered FSM state encoding, for debug/display.

Function
REQ-015 Block SHALL sample speed on every tick_sample in all states into prev_speed, and SHALL set prev_valid on the first sample after reset.
REQ-016 On tick_sample, decel SHALL be prev_speed - speed when prev_valid and prev_speed > speed, else 0; 8-bit saturating, no wrap; latched into decel_out on the same edge.
REQ-017 FSM states SHALL be IDLE=0, ARMED=1, CONFIRM=2, FIRE=3, HOLDOFF=4; state_out SHALL equal the current state.
REQ-018 IDLE -> ARMED on tick_sample when brake_pressed=1, is_accel_pressed=0, and speed >= MIN_SPEED.
REQ-019 ARMED: on tick_sample with decel >= DECEL_THRESH, hit_cnt SHALL become 1, and the next state SHALL be FIRE if CONFIRM_N=1, else CONFIRM.
REQ-020 CONFIRM: on tick_sample with a hit, hit_cnt SHALL increment, and the FSM SHALL go to FIRE when hit_cnt+1 = CONFIRM_N; on a miss, it SHALL go to ARMED with hit_cnt=0.
REQ-021 In ARMED or CONFIRM, brake_pressed=0 or is_accel_pressed=1 SHALL force IDLE on the next clk with hit_cnt=0, irrespective of tick_sample; abort has priority over a simultaneous hit.
REQ-022 FIRE SHALL last exactly one clk; ess_trigger SHALL be 1 exactly while state=FIRE and 0 otherwise; next state SHALL be HOLDOFF.
REQ-023 HOLDOFF: holdoff_cnt SHALL be held at 0 while ess_active=1; once ess_active=0, it SHALL count tick_sample pulses, and the FSM SHALL enter IDLE on the tick where the count reaches HOLDOFF_N.
REQ-024 HOLDOFF SHALL ignore brake, accelerator and decel; no second ess_trigger is possible before IDLE is re-entered.
REQ-025 ess_active re-asserting during the HOLDOFF count SHALL restart holdoff_cnt from 0.
REQ-026 A speed increase SHALL yield decel=0 (a miss), never a wrapped large value.
REQ-027 A tick_sample in FIRE SHALL update prev_speed and decel_out only; FSM behaviour is per REQ-022.

Reset
REQ-028 While rst=1: state=IDLE, ess_trigger=0, decel_out=0, state_out=0, prev_speed=0, prev_valid=0, hit_cnt=0, holdoff_cnt=0.
REQ-029 rst asserted mid-operation (any state, including FIRE) SHALL clear everything per REQ-028 immediately with no trigger pulse; the first post-reset tick SHALL produce decel=0.

Verification
REQ-030 Brake held, speeds 60,50,41 on successive ticks (decel 10,9) -> IDLE, ARMED, CONFIRM, FIRE; one ess_trigger pulse 1 clk after the third tick; state then HOLDOFF.
REQ-031 Brake held, speeds 60,50,47,37 -> hit then miss (3) returns to ARMED, hit_cnt=0; no trigger on the 37 tick (single hit).
REQ-032 ARMED/CONFIRM with is_accel_pressed=1 on the same clk as a qualifying tick -> IDLE next clk, no trigger, decel_out still updated.
REQ-033 After FIRE, hold ess_active=1 for 50 ticks, then 0 -> state stays HOLDOFF until exactly 10 further ticks, then IDLE; hard braking during holdoff produces no trigger.
REQ-034 Speed 25 with brake and decel 20 -> remains IDLE (below MIN_SPEED); speed 10 then 200 -> decel_out=0.
REQ-035 rst pulsed while in CONFIRM -> all outputs 0 at once, and the first tick after release gives decel_out=0 regardless of speed.

Source files
------------

// File: rtl/ess_decel_detector.sv
// ess_decel_detector
// Watches the per-sample speed drop while the driver is braking and requests
// the emergency stop signal (ESS) after CONFIRM_N consecutive hard-braking
// samples. After a request it locks out re-arming until the warning-light
// block has finished blinking and HOLDOFF_N further samples have passed.
module ess_decel_detector #(
    parameter int MIN_SPEED    = 30,
    parameter int DECEL_THRESH = 8,
    parameter int CONFIRM_N    = 2,
    parameter int HOLDOFF_N    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_sample,
    input  logic [7:0] speed,
    input  logic       brake_pressed,
    input  logic       is_accel_pressed,
    input  logic       ess_active,
    output logic       ess_trigger,
    output logic [7:0] decel_out,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CONFIRM = 3'd2,
        FIRE    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  hit_cnt_r;
    logic [2:0]  hit_cnt_s;
    logic [7:0]  holdoff_cnt_r;
    logic [7:0]  holdoff_cnt_s;
    logic [7:0]  prev_speed_r;
    logic        prev_valid_r;
    logic [7:0]  decel_r;
    logic        trig_r;

    logic [7:0]  decel_s;
    logic        hit_s;
    logic        abort_s;
    logic        arm_s;
    logic [3:0]  hit_inc_s;
    logic [8:0]  hold_inc_s;

    // Speed drop since the previous sample; a rise (or no history) is 0,
    // so the result can never wrap to a large value.
    function automatic logic [7:0] speed_drop(input logic [7:0] prev,
                                              input logic [7:0] cur,
                                              input logic       valid);
        logic [7:0] drop;
        if (valid && (prev > cur)) begin
            drop = prev - cur;
        end else begin
            drop = 8'd0;
        end
        return drop;
    endfunction

    // Per-sample qualifiers shared by the state logic.
    always_comb begin
        decel_s    = speed_drop(prev_speed_r, speed, prev_valid_r);
        hit_s      = tick_sample && (decel_s >= 8'(DECEL_THRESH));
        abort_s    = !brake_pressed || is_accel_pressed;
        arm_s      = tick_sample && brake_pressed && !is_accel_pressed &&
                     (speed >= 8'(MIN_SPEED));
        hit_inc_s  = {1'b0, hit_cnt_r} + 4'd1;
        hold_inc_s = {1'b0, holdoff_cnt_r} + 9'd1;
    end

    // Next-state and counter logic; abort wins over a simultaneous hit.
    always_comb begin
        state_s       = state_r;
        hit_cnt_s     = hit_cnt_r;
        holdoff_cnt_s = holdoff_cnt_r;
        case (state_r)
            IDLE: begin
                hit_cnt_s     = 3'd0;
                holdoff_cnt_s = 8'd0;
                if (arm_s) begin
                    state_s = ARMED;
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED, CONFIRM: begin
                holdoff_cnt_s = 8'd0;
                if (abort_s) begin
                    state_s   = IDLE;
                    hit_cnt_s = 3'd0;
                end else if (tick_sample) begin
                    if (hit_s) begin
                        hit_cnt_s = hit_inc_s[2:0];
                        if (hit_inc_s == 4'(CONFIRM_N)) begin
                            state_s = FIRE;
                        end else begin
                            state_s = CONFIRM;
                        end
                    end else begin
                        state_s   = ARMED;
                        hit_cnt_s = 3'd0;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            FIRE: begin
                state_s       = HOLDOFF;
                hit_cnt_s     = 3'd0;
                holdoff_cnt_s = 8'd0;
            end
            HOLDOFF: begin
                hit_cnt_s = 3'd0;
                if (ess_active) begin
                    holdoff_cnt_s = 8'd0;
                end else if (tick_sample) begin
                    if (hold_inc_s == 9'(HOLDOFF_N)) begin
                        state_s       = IDLE;
                        holdoff_cnt_s = 8'd0;
                    end else begin
                        holdoff_cnt_s = hold_inc_s[7:0];
                    end
                end else begin
                    holdoff_cnt_s = holdoff_cnt_r;
                end
            end
            default: begin
                state_s       = IDLE;
                hit_cnt_s     = 3'd0;
                holdoff_cnt_s = 8'd0;
            end
        endcase
    end

    // State, counters, sample history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            hit_cnt_r     <= 3'd0;
            holdoff_cnt_r <= 8'd0;
            prev_speed_r  <= 8'd0;
            prev_valid_r  <= 1'b0;
            decel_r       <= 8'd0;
            trig_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            hit_cnt_r     <= hit_cnt_s;
            holdoff_cnt_r <= holdoff_cnt_s;
            trig_r        <= (state_s == FIRE);
            if (tick_sample) begin
                prev_speed_r <= speed;
                prev_valid_r <= 1'b1;
                decel_r      <= decel_s;
            end else begin
                prev_speed_r <= prev_speed_r;
                prev_valid_r <= prev_valid_r;
                decel_r      <= decel_r;
            end
        end
    end

    assign ess_trigger = trig_r;
    assign decel_out   = decel_r;
    assign state_out   = state_r;

endmodule

// File: tb/tb_ess_decel_detector.sv
// Bench for ess_decel_detector: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model through a scoreboard.
module tb_ess_decel_detector;

    localparam int MIN = 30;
    localparam int TH  = 8;
    localparam int CN  = 2;
    localparam int HN  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_sample;
    logic [7:0] speed;
    logic       brake_pressed;
    logic       is_accel_pressed;
    logic       ess_active;
    logic       ess_trigger;
    logic [7:0] decel_out;
    logic [2:0] state_out;

    ess_decel_detector #(
        .MIN_SPEED(MIN), .DECEL_THRESH(TH), .CONFIRM_N(CN), .HOLDOFF_N(HN)
    ) dut (
        .clk(clk), .rst(rst), .tick_sample(tick_sample), .speed(speed),
        .brake_pressed(brake_pressed), .is_accel_pressed(is_accel_pressed),
        .ess_active(ess_active), .ess_trigger(ess_trigger),
        .decel_out(decel_out), .state_out(state_out)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       trig;
        logic [7:0] decel;
        logic [2:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_trig  = 0;

    // behavioural model state
    int m_st = 0, m_prev = 0, m_valid = 0, m_streak = 0, m_hold = 0, m_decel = 0;
    // driven levels
    bit br_l = 1'b0, ac_l = 1'b0, es_l = 1'b0;
    int sp_l = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: one clock of behaviour from the rules, result queued.
    task automatic model(input bit r, input bit t, input int sp,
                         input bit br, input bit ac, input bit es);
        int   d;
        bit   hit;
        exp_t e;
        if (r) begin
            m_st = 0; m_prev = 0; m_valid = 0; m_streak = 0; m_hold = 0; m_decel = 0;
        end else begin
            d   = m_decel;
            hit = 1'b0;
            if (t) begin
                d   = (m_valid != 0 && m_prev > sp) ? (m_prev - sp) : 0;
                hit = (d >= TH);
            end
            case (m_st)
                0: if (t && br && !ac && sp >= MIN) m_st = 1;
                1, 2: begin
                    if (!br || ac) begin
                        m_st = 0; m_streak = 0;
                    end else if (t) begin
                        if (hit) begin
                            m_streak++;
                            m_st = (m_streak >= CN) ? 3 : 2;
                        end else begin
                            m_streak = 0; m_st = 1;
                        end
                    end
                end
                3: begin m_st = 4; m_hold = 0; m_streak = 0; end
                4: begin
                    if (es) m_hold = 0;
                    else if (t) begin
                        m_hold++;
                        if (m_hold >= HN) begin m_st = 0; m_hold = 0; end
                    end
                end
                default: m_st = 0;
            endcase
            if (t) begin m_prev = sp; m_valid = 1; m_decel = d; end
        end
        e.trig  = (m_st == 3);
        e.decel = m_decel[7:0];
        e.st    = m_st[2:0];
        exp_q.push_back(e);
    endtask

    // Drive one clock's inputs at the falling edge and queue the expectation.
    task automatic cyc(input bit r, input bit t, input int sp);
        @(negedge clk);
        rst = r; tick_sample = t; speed = sp[7:0];
        brake_pressed = br_l; is_accel_pressed = ac_l; ess_active = es_l;
        sp_l = sp;
        model(r, t, sp, br_l, ac_l, es_l);
    endtask

    task automatic tick(input int sp);
        cyc(1'b0, 1'b1, sp);
    endtask

    task automatic gap(input int n);
        repeat (n) cyc(1'b0, 1'b0, sp_l);
    endtask

    // Wait until the queued clock has been applied and settled.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every presented output set with the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("trigger", ess_trigger, e.trig);
            check("decel",   decel_out,   e.decel);
            check("state",   state_out,   e.st);
        end
        if (ess_trigger) n_trig++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int trig0;
        int r;
        rst = 1'b1; tick_sample = 1'b0; speed = 8'd0;
        brake_pressed = 1'b0; is_accel_pressed = 1'b0; ess_active = 1'b0;
        model(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_state", state_out, 0);
        check("reset_trig",  ess_trigger, 0);
        check("reset_decel", decel_out, 0);
        cyc(1'b1, 1'b0, 0);
        gap(2);

        // 60,50,41 with brake held: arm, confirm, fire, holdoff
        br_l = 1'b1;
        tick(60); settle(); check("a_armed", state_out, 1);
        gap(1);
        tick(50); settle(); check("a_confirm", state_out, 2);
        check("a_decel10", decel_out, 10);
        gap(1);
        tick(41); settle(); check("a_fire", state_out, 3);
        check("a_trig", ess_trigger, 1);
        check("a_decel9", decel_out, 9);
        gap(1); settle(); check("a_holdoff", state_out, 4);
        check("a_trig_off", ess_trigger, 0);
        repeat (HN - 1) begin tick(41); gap(1); end
        settle(); check("a_still_hold", state_out, 4);
        tick(41); settle(); check("a_idle", state_out, 0);

        // hit then miss returns to ARMED; later single hit does not fire
        tick(60); tick(50); tick(47); settle();
        check("b_miss_armed", state_out, 1);
        tick(37); settle();
        check("b_single_hit", state_out, 2);
        check("b_no_trig", ess_trigger, 0);
        tick(37); settle(); check("b_back_armed", state_out, 1);

        // accelerator on a qualifying tick: abort wins, decel still latched
        ac_l = 1'b1; tick(27); settle();
        check("c_abort_idle", state_out, 0);
        check("c_abort_decel", decel_out, 10);
        check("c_abort_trig", ess_trigger, 0);
        ac_l = 1'b0; tick(60);
        br_l = 1'b0; gap(1); settle();
        check("c_release_idle", state_out, 0);

        // fire, hold ess_active for 50 ticks of hard braking, then count out
        trig0 = n_trig;
        br_l = 1'b1;
        tick(100); tick(90); tick(80);
        es_l = 1'b1;
        for (int i = 0; i < 50; i++) begin tick((i % 2 == 0) ? 250 : 200); gap(1); end
        settle(); check("d_hold_ess", state_out, 4);
        es_l = 1'b0;
        for (int i = 0; i < HN - 1; i++) begin tick((i % 2 == 0) ? 250 : 200); gap(1); end
        settle(); check("d_hold_9", state_out, 4);
        tick(150); settle(); check("d_idle_10", state_out, 0);
        check("d_one_trigger", n_trig - trig0, 1);
        br_l = 1'b0; gap(1);

        // below minimum speed stays idle; speed rise gives zero decel
        tick(45);
        br_l = 1'b1; tick(25); settle();
        check("e_low_idle", state_out, 0);
        check("e_decel20", decel_out, 20);
        tick(10); tick(200); settle();
        check("e_rise_zero", decel_out, 0);
        br_l = 1'b0; gap(1);

        // reset in CONFIRM clears at once, first tick after gives decel 0
        br_l = 1'b1;
        tick(100); tick(90); settle();
        check("f_confirm", state_out, 2);
        cyc(1'b1, 1'b0, 90);
        #1;
        check("f_rst_state", state_out, 0);
        check("f_rst_decel", decel_out, 0);
        check("f_rst_trig",  ess_trigger, 0);
        cyc(1'b1, 1'b0, 90);
        gap(1);
        tick(40); settle();
        check("f_first_decel", decel_out, 0);
        check("f_rearm", state_out, 1);
        br_l = 1'b0; gap(1);

        // random traffic
        sp_l = 120;
        for (int i = 0; i < 4000; i++) begin
            int sp;
            if ($urandom_range(0, 39) == 0) br_l = ~br_l;
            ac_l = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 24) == 0) es_l = ~es_l;
            r = ($urandom_range(0, 599) == 0) ? 1 : 0;
            sp = sp_l;
            if ($urandom_range(0, 2) == 0) begin
                sp = sp + $urandom_range(0, 40) - 20;
                if ($urandom_range(0, 60) == 0) sp = $urandom_range(0, 255);
                if (sp < 20) sp = 150;
                if (sp > 255) sp = 255;
                cyc(r[0], 1'b1, sp);
            end else begin
                cyc(r[0], 1'b0, sp);
            end
        end

        repeat (4) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
